// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: owner states and port indices.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

endpackage

// File: rtl/rr_burst_ctrl.sv
// Round-robin owner FSM with a bounded burst counter. An owner keeps the
// memory while it requests, but yields after BURST_MAX beats if the peer waits.
module rr_burst_ctrl
  import dmem_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt_vld_o,
  output logic gnt_sel_o
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             gnt_vld, gnt_sel;

  // Grant decision and next owner/counter; reset suppresses any grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = P_CPU;
    case (state_q)
      ST_OWN0: begin
        if (req0_i && ((cnt_q < CNT_MAX) || !req1_i)) begin
          gnt_vld = 1'b1;
          gnt_sel = P_CPU;
        end else if (req1_i) begin
          gnt_vld = 1'b1;
          gnt_sel = P_LDR;
        end
      end
      ST_OWN1: begin
        if (req1_i && ((cnt_q < CNT_MAX) || !req0_i)) begin
          gnt_vld = 1'b1;
          gnt_sel = P_LDR;
        end else if (req0_i) begin
          gnt_vld = 1'b1;
          gnt_sel = P_CPU;
        end
      end
      default: begin
        if (req0_i && req1_i) begin
          gnt_vld = 1'b1;
          gnt_sel = ~last_q;
        end else if (req0_i) begin
          gnt_vld = 1'b1;
          gnt_sel = P_CPU;
        end else if (req1_i) begin
          gnt_vld = 1'b1;
          gnt_sel = P_LDR;
        end
      end
    endcase
    if (rst_i) gnt_vld = 1'b0;

    state_d = ST_IDLE;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt_vld) begin
      last_d  = gnt_sel;
      state_d = gnt_sel ? ST_OWN1 : ST_OWN0;
      if (state_q == state_d) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = CNT_W'(1);
      end
    end
  end

  // Owner state, beat counter and last owner; last owner starts at the loader
  // so the CPU wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= P_LDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt_vld_o = gnt_vld;
  assign gnt_sel_o = gnt_sel;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (m0) and the loader (m1).
// Grants steer the request straight onto the memory bus; load data returns
// one cycle later on the port that issued the read.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic gnt_vld, gnt_sel;
  logic rd_pend_q, rd_pend_d;
  logic rd_port_q, rd_port_d;

  rr_burst_ctrl #(
    .BURST_MAX(BURST_MAX)
  ) u_ctrl (
    .clk_i    (clk),
    .rst_i    (rst),
    .req0_i   (m0_req),
    .req1_i   (m1_req),
    .gnt_vld_o(gnt_vld),
    .gnt_sel_o(gnt_sel)
  );

  assign m0_gnt = gnt_vld && (gnt_sel == P_CPU);
  assign m1_gnt = gnt_vld && (gnt_sel == P_LDR);

  // Memory bus mux: drive the granted port's request; bus idles at zero.
  always_comb begin
    mem_en    = gnt_vld;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_vld) begin
      if (gnt_sel == P_LDR) begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end else begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
    end
  end

  // Track which port is owed read data next cycle.
  always_comb begin
    rd_pend_d = gnt_vld && !mem_we;
    rd_port_d = gnt_vld ? gnt_sel : rd_port_q;
  end

  // Read-return register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= P_CPU;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  // A read pending across a reset edge is dropped, so rvalid is masked by rst.
  assign m0_rvalid = rd_pend_q && !rst && (rd_port_q == P_CPU);
  assign m1_rvalid = rd_pend_q && !rst && (rd_port_q == P_LDR);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem_model [256];

  int checks = 0;
  int passed = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid} !== 6'b0)
        $display("FAIL reset_outputs cyc%0d: got %b want 000000", c,
                 {m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid});
      else passed++;
      checks++;
      if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0)
        $display("FAIL reset_rdata cyc%0d: got %h/%h want 0/0", c, m0_rdata, m1_rdata);
      else passed++;
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0)
      $display("FAIL reset_first_tie: got m0_gnt=%b m1_gnt=%b want 1/0", m0_gnt, m1_gnt);
    else passed++;
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF)
      $display("FAIL preload_store: got gnt=%b we=%b wdata=%h want 1/1/deadbeef",
               m1_gnt, mem_we, mem_wdata);
    else passed++;
    tick();
    m1_req = 1'b0;
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10)
      $display("FAIL single_read_grant: got gnt=%b en=%b we=%b addr=%h want 1/1/0/10",
               m0_gnt, mem_en, mem_we, mem_addr);
    else passed++;
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF)
      $display("FAIL single_read_data: got rvalid=%b rdata=%h want 1/deadbeef",
               m0_rvalid, m0_rdata);
    else passed++;
    checks++;
    if (m1_rvalid !== 1'b0 || m0_gnt !== 1'b0)
      $display("FAIL single_read_other: got m1_rvalid=%b m0_gnt=%b want 0/0", m1_rvalid, m0_gnt);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0)
      $display("FAIL single_read_once: got rvalid=%b want 0", m0_rvalid);
    else passed++;
  endtask

  task automatic test_contention();
    logic want [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] want_addr;
    tick();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h300; m1_wdata = 32'h1;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1)
      $display("FAIL contention_setup: got m1_gnt=%b want 1", m1_gnt);
    else passed++;
    tick();
    m1_req = 1'b0;
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      want_addr = want[c] ? 32'h200 : 32'h100;
      checks++;
      if (m0_gnt !== !want[c] || m1_gnt !== want[c])
        $display("FAIL contention_gnt cyc%0d: got m0=%b m1=%b want m0=%b m1=%b",
                 c, m0_gnt, m1_gnt, !want[c], want[c]);
      else passed++;
      checks++;
      if (mem_addr !== want_addr)
        $display("FAIL contention_addr cyc%0d: got %h want %h", c, mem_addr, want_addr);
      else passed++;
    end
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_uncontended_burst();
    logic [31:0] expd;
    for (int i = 0; i < 10; i++) begin
      m1_req = 1'b1; m1_we = 1'b1;
      m1_addr = 32'h40 + 32'(4 * i);
      m1_wdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      checks++;
      if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== m1_addr)
        $display("FAIL burst_store beat%0d: got gnt=%b we=%b addr=%h want 1/1/%h",
                 i, m1_gnt, mem_we, mem_addr, m1_addr);
      else passed++;
      tick();
    end
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL burst_idle: got gnt=%b en=%b want 0/0", m1_gnt, mem_en);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      tick();
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (m1_gnt !== 1'b1)
        $display("FAIL burst_load_gnt beat%0d: got %b want 1", i, m1_gnt);
      else passed++;
      if (i == 0) begin
        checks++;
        if (m1_rvalid !== 1'b0)
          $display("FAIL burst_load_first_rvalid: got %b want 0", m1_rvalid);
        else passed++;
      end else begin
        expd = 32'hA000_0000 + 32'(i - 1);
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== expd)
          $display("FAIL burst_load_data beat%0d: got rvalid=%b rdata=%h want 1/%h",
                   i - 1, m1_rvalid, m1_rdata, expd);
        else passed++;
      end
    end
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hA000_0009)
      $display("FAIL burst_load_last: got rvalid=%b rdata=%h want 1/a0000009", m1_rvalid, m1_rdata);
    else passed++;
    tick();
  endtask

  task automatic test_pipelining();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1)
      $display("FAIL pipe_m0_gnt: got %b want 1", m0_gnt);
    else passed++;
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_gnt !== 1'b1)
      $display("FAIL pipe_overlap: got m0_rvalid=%b m0_rdata=%h m1_gnt=%b want 1/deadbeef/1",
               m0_rvalid, m0_rdata, m1_gnt);
    else passed++;
    checks++;
    if (m1_rvalid !== 1'b0)
      $display("FAIL pipe_m1_early: got m1_rvalid=%b want 0", m1_rvalid);
    else passed++;
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hA000_0001 || m0_rvalid !== 1'b0)
      $display("FAIL pipe_m1_data: got m1_rvalid=%b m1_rdata=%h m0_rvalid=%b want 1/a0000001/0",
               m1_rvalid, m1_rdata, m0_rvalid);
    else passed++;
    tick();
  endtask

  task automatic test_mid_read_reset();
    logic want [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1)
      $display("FAIL midrst_grant: got %b want 1", m0_gnt);
    else passed++;
    tick();
    m0_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || mem_en !== 1'b0)
      $display("FAIL midrst_during: got rvalid=%b rdata=%h en=%b want 0/0/0",
               m0_rvalid, m0_rdata, mem_en);
    else passed++;
    tick();
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0)
          $display("FAIL midrst_after: got m0_rvalid=%b m1_rvalid=%b want 0/0", m0_rvalid, m1_rvalid);
        else passed++;
      end
      checks++;
      if (m0_gnt !== !want[c] || m1_gnt !== want[c])
        $display("FAIL midrst_burst cyc%0d: got m0=%b m1=%b want m0=%b m1=%b",
                 c, m0_gnt, m1_gnt, !want[c], want[c]);
      else passed++;
    end
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_uncontended_burst();
    test_pipelining();
    test_mid_read_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
